// File: rtl/sram_bist_pkg.sv
// sram_bist_pkg
// Shared types and constants for the March C- BIST controller (sram_1p_march_bist).
//   bist_state_t : controller FSM states
//   elem_idx_t   : march element index (E0..E5)
//   MARCH_TABLE  : per element: address order, op count, op kind, data polarity
//   BG_PASS0/1   : data backgrounds, sliced to the macro width by the user
//                  (BG_PASS1 is only used when SRAM_BIST_ALT_BACKGROUND_EN is defined)
// Data widths up to 64 bits are supported by the background constants.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bist_state_t;

    typedef logic [2:0] elem_idx_t;

    localparam elem_idx_t LAST_ELEM = 3'd5;

    // Bit i of wr/inv describes op i at one address.
    typedef struct packed {
        logic       down;     // 1: addresses N-1..0, 0: 0..N-1
        logic       two_ops;  // 1: two ops per address, 0: one op
        logic [1:0] wr;       // 1: write, 0: read
        logic [1:0] inv;      // 1: data is ~B, 0: data is B
    } march_elem_t;

    // Indexed by the full 3-bit element index; the last two rows are never reached.
    localparam march_elem_t MARCH_TABLE [8] = '{
        '{down: 1'b0, two_ops: 1'b0, wr: 2'b01, inv: 2'b00},  // E0 up   (wB)
        '{down: 1'b0, two_ops: 1'b1, wr: 2'b10, inv: 2'b10},  // E1 up   (rB,  w~B)
        '{down: 1'b0, two_ops: 1'b1, wr: 2'b10, inv: 2'b01},  // E2 up   (r~B, wB)
        '{down: 1'b1, two_ops: 1'b1, wr: 2'b10, inv: 2'b10},  // E3 down (rB,  w~B)
        '{down: 1'b1, two_ops: 1'b1, wr: 2'b10, inv: 2'b01},  // E4 down (r~B, wB)
        '{down: 1'b0, two_ops: 1'b0, wr: 2'b00, inv: 2'b00},  // E5 up   (rB)
        '0,
        '0
    };

    localparam logic [63:0] BG_PASS0 = 64'h0;
    localparam logic [63:0] BG_PASS1 = {32{2'b01}};

endpackage

// File: rtl/sram_bist_cmp.sv
// sram_bist_cmp
// Read-compare stage of the March BIST: registers each issued read (address and
// expected data), compares the macro's read data one cycle later, keeps the first
// failing address/syndrome and a saturating miscompare count.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear of pipeline and results (start of a run)
//   rd_en      : a read is being sampled by the macro at this edge
//   rd_addr    : address of that read
//   rd_exp     : data that read must return
//   dout       : macro read data (valid the cycle after the read)
//   fail       : sticky miscompare flag
//   fail_addr  : address of the first miscompare
//   fail_data  : syndrome (dout ^ expected) of the first miscompare
//   fail_cnt   : miscompare count, saturating at all-ones
module sram_bist_cmp
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH     = 16,
    parameter int P_ADDR_WIDTH     = 12,
    parameter int P_FAIL_CNT_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        rd_en,
    input  logic [P_ADDR_WIDTH-1:0]     rd_addr,
    input  logic [P_DATA_WIDTH-1:0]     rd_exp,
    input  logic [P_DATA_WIDTH-1:0]     dout,
    output logic                        fail,
    output logic [P_ADDR_WIDTH-1:0]     fail_addr,
    output logic [P_DATA_WIDTH-1:0]     fail_data,
    output logic [P_FAIL_CNT_WIDTH-1:0] fail_cnt
);

    logic                    vld_q;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0] exp_q;
    logic [P_DATA_WIDTH-1:0] syndrome;
    logic                    miscompare;

    assign syndrome   = dout ^ exp_q;
    assign miscompare = vld_q && (syndrome != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= 1'b0;
            addr_q    <= '0;
            exp_q     <= '0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_cnt  <= '0;
        end else if (clr) begin
            vld_q     <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            fail_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the
            // pre-edge value of the others (fail is tested before it is set).
            vld_q  <= rd_en;
            addr_q <= rd_addr;
            exp_q  <= rd_exp;
            if (miscompare) begin
                fail <= 1'b1;
                if (!fail) begin
                    fail_addr <= addr_q;
                    fail_data <= syndrome;
                end
                if (fail_cnt != '1) begin
                    fail_cnt <= fail_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_1p_march_bist.sv
// sram_1p_march_bist
// March C- BIST controller for single-port SRAM macros with a BIST port.
// Runs E0 up(wB) E1 up(rB,w~B) E2 up(r~B,wB) E3 down(rB,w~B) E4 down(r~B,wB)
// E5 up(rB), one op per cycle, and reports pass/fail, first failing address,
// its syndrome and a saturating failure count.
// Optional feature macro: SRAM_BIST_ALT_BACKGROUND_EN -- when defined a second
// pass with background 0101..01 follows pass 0 immediately.
// Ports:
//   A_BIST_CLK, A_BIST_RST : clock, asynchronous active-high reset
//   BIST_START             : start request (accepted in IDLE/DONE)
//   A_DOUT                 : macro read data
//   A_BIST_EN/MEN/WEN/REN  : macro port select and strobes
//   A_BIST_ADDR/DIN/BM     : macro address, write data, bit mask
//   BIST_BUSY, BIST_DONE   : test running / finished
//   BIST_FAIL, BIST_FAIL_ADDR, BIST_FAIL_DATA, BIST_FAIL_CNT : results
module sram_1p_march_bist
    import sram_bist_pkg::*;
#(
    parameter int P_DATA_WIDTH     = 16,
    parameter int P_ADDR_WIDTH     = 12,
    parameter int P_FAIL_CNT_WIDTH = 8
) (
    input  logic                        A_BIST_CLK,
    input  logic                        A_BIST_RST,
    input  logic                        BIST_START,
    input  logic [P_DATA_WIDTH-1:0]     A_DOUT,
    output logic                        A_BIST_EN,
    output logic                        A_BIST_MEN,
    output logic                        A_BIST_WEN,
    output logic                        A_BIST_REN,
    output logic [P_ADDR_WIDTH-1:0]     A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0]     A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0]     A_BIST_BM,
    output logic                        BIST_BUSY,
    output logic                        BIST_DONE,
    output logic                        BIST_FAIL,
    output logic [P_ADDR_WIDTH-1:0]     BIST_FAIL_ADDR,
    output logic [P_DATA_WIDTH-1:0]     BIST_FAIL_DATA,
    output logic [P_FAIL_CNT_WIDTH-1:0] BIST_FAIL_CNT
);

    localparam logic [P_DATA_WIDTH-1:0] BG0 = BG_PASS0[P_DATA_WIDTH-1:0];
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
    localparam logic [P_DATA_WIDTH-1:0] BG1 = BG_PASS1[P_DATA_WIDTH-1:0];
`endif

    // Counters describe the op currently presented on the macro port.
    bist_state_t             state_q, state_d;
    elem_idx_t               elem_q, elem_d;
    logic                    op_q, op_d;
    logic [P_ADDR_WIDTH-1:0] addr_q, addr_d;
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
    logic                    pass_q, pass_d;
`endif

    logic                    start_run;
    logic                    last_addr;
    logic                    present;
    logic                    is_wr;
    logic [P_DATA_WIDTH-1:0] bg;
    logic [P_DATA_WIDTH-1:0] pattern;
    logic [P_DATA_WIDTH-1:0] exp_q;

    // Next-state and next-op decode; the output registers load the decode of the
    // next op so the macro sees each op one full cycle before it samples it.
    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned (no latches).
        state_d   = state_q;
        elem_d    = elem_q;
        op_d      = op_q;
        addr_d    = addr_q;
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
        pass_d    = pass_q;
`endif
        start_run = 1'b0;
        last_addr = MARCH_TABLE[elem_q].down ? (addr_q == '0) : (addr_q == '1);

        case (state_q)
            IDLE, DONE: begin
                if (BIST_START) begin
                    state_d   = RUN;
                    elem_d    = '0;
                    op_d      = 1'b0;
                    addr_d    = '0;
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
                    pass_d    = 1'b0;
`endif
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (MARCH_TABLE[elem_q].two_ops && !op_q) begin
                    op_d = 1'b1;
                end else if (!last_addr) begin
                    op_d   = 1'b0;
                    addr_d = MARCH_TABLE[elem_q].down ? addr_q - 1'b1 : addr_q + 1'b1;
                end else if (elem_q != LAST_ELEM) begin
                    // Element boundary: no idle cycle, address restarts at the
                    // end the new element's direction begins from.
                    elem_d = elem_q + 3'd1;
                    op_d   = 1'b0;
                    addr_d = MARCH_TABLE[elem_d].down ? '1 : '0;
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
                end else if (!pass_q) begin
                    pass_d = 1'b1;
                    elem_d = '0;
                    op_d   = 1'b0;
                    addr_d = '0;
`endif
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        present = (state_d == RUN);
        is_wr   = MARCH_TABLE[elem_d].wr[op_d];
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
        bg      = pass_d ? BG1 : BG0;
`else
        bg      = BG0;
`endif
        pattern = MARCH_TABLE[elem_d].inv[op_d] ? ~bg : bg;
    end

    always_ff @(posedge A_BIST_CLK or posedge A_BIST_RST) begin
        if (A_BIST_RST) begin
            state_q     <= IDLE;
            elem_q      <= '0;
            op_q        <= 1'b0;
            addr_q      <= '0;
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
            pass_q      <= 1'b0;
`endif
            A_BIST_EN   <= 1'b0;
            A_BIST_MEN  <= 1'b0;
            A_BIST_WEN  <= 1'b0;
            A_BIST_REN  <= 1'b0;
            A_BIST_ADDR <= '0;
            A_BIST_DIN  <= '0;
            A_BIST_BM   <= '0;
            exp_q       <= '0;
            BIST_BUSY   <= 1'b0;
            BIST_DONE   <= 1'b0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
            pass_q      <= pass_d;
`endif
            A_BIST_EN   <= present;
            A_BIST_MEN  <= present;
            A_BIST_WEN  <= present && is_wr;
            A_BIST_REN  <= present && !is_wr;
            A_BIST_ADDR <= present ? addr_d : '0;
            A_BIST_DIN  <= (present && is_wr) ? pattern : '0;
            A_BIST_BM   <= {P_DATA_WIDTH{present}};
            exp_q       <= pattern;
            BIST_BUSY   <= (state_d == RUN) || (state_d == DRAIN);
            BIST_DONE   <= (state_d == DONE);
        end
    end

    sram_bist_cmp #(
        .P_DATA_WIDTH    (P_DATA_WIDTH),
        .P_ADDR_WIDTH    (P_ADDR_WIDTH),
        .P_FAIL_CNT_WIDTH(P_FAIL_CNT_WIDTH)
    ) u_cmp (
        .clk      (A_BIST_CLK),
        .rst      (A_BIST_RST),
        .clr      (start_run),
        .rd_en    (A_BIST_REN),
        .rd_addr  (A_BIST_ADDR),
        .rd_exp   (exp_q),
        .dout     (A_DOUT),
        .fail     (BIST_FAIL),
        .fail_addr(BIST_FAIL_ADDR),
        .fail_data(BIST_FAIL_DATA),
        .fail_cnt (BIST_FAIL_CNT)
    );

endmodule

// File: tb/tb_sram_1p_march_bist.sv
// tb_sram_1p_march_bist
// Bench for sram_1p_march_bist with a behavioural SRAM (stuck-at overlay) and a
// reference model: the expected op stream is built from the march algorithm as
// a list, and expected results come from replaying that list on an array.
module tb_sram_1p_march_bist;

    localparam int AW = 4;
    localparam int DW = 16;
    localparam int CW = 4;
    localparam int N  = 1 << AW;
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int OPS     = 10 * N * PASSES;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] dout;
    logic          en, men, wen, ren;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, bm;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [CW-1:0] fail_cnt;

    always #5 clk = ~clk;

    sram_1p_march_bist #(
        .P_DATA_WIDTH    (DW),
        .P_ADDR_WIDTH    (AW),
        .P_FAIL_CNT_WIDTH(CW)
    ) dut (
        .A_BIST_CLK    (clk),
        .A_BIST_RST    (rst),
        .BIST_START    (start),
        .A_DOUT        (dout),
        .A_BIST_EN     (en),
        .A_BIST_MEN    (men),
        .A_BIST_WEN    (wen),
        .A_BIST_REN    (ren),
        .A_BIST_ADDR   (addr),
        .A_BIST_DIN    (din),
        .A_BIST_BM     (bm),
        .BIST_BUSY     (busy),
        .BIST_DONE     (done),
        .BIST_FAIL     (fail),
        .BIST_FAIL_ADDR(fail_addr),
        .BIST_FAIL_DATA(fail_data),
        .BIST_FAIL_CNT (fail_cnt)
    );

    // Behavioural macro: synchronous read, stuck-at faults applied on read.
    logic [DW-1:0] mem    [N];
    logic [DW-1:0] stuck1 [N];
    logic [DW-1:0] stuck0 [N];

    always @(posedge clk) begin
        if (en && men && wen) mem[addr] <= (din & bm) | (mem[addr] & ~bm);
        if (en && men && ren) dout <= (mem[addr] | stuck1[addr]) & ~stuck0[addr];
    end

    // Reference op stream.
    typedef struct {
        bit            wr;
        int            a;
        logic [DW-1:0] d;
    } op_t;

    op_t ref_ops[$];

    function automatic void push_op(input bit wr, input int a, input logic [DW-1:0] d);
        op_t o;
        o.wr = wr;
        o.a  = a;
        o.d  = d;
        ref_ops.push_back(o);
    endfunction

    function automatic void build_ref();
        logic [DW-1:0] b;
        ref_ops.delete();
        for (int p = 0; p < PASSES; p++) begin
            b = (p == 0) ? '0 : {(DW/2){2'b01}};
            for (int i = 0; i < N; i++) push_op(1'b1, i, b);
            for (int i = 0; i < N; i++) begin push_op(1'b0, i, b);  push_op(1'b1, i, ~b); end
            for (int i = 0; i < N; i++) begin push_op(1'b0, i, ~b); push_op(1'b1, i, b);  end
            for (int i = N - 1; i >= 0; i--) begin push_op(1'b0, i, b);  push_op(1'b1, i, ~b); end
            for (int i = N - 1; i >= 0; i--) begin push_op(1'b0, i, ~b); push_op(1'b1, i, b);  end
            for (int i = 0; i < N; i++) push_op(1'b0, i, b);
        end
    endfunction

    // Replays the op stream on a plain array with the current faults.
    function automatic logic [63:0] model_status();
        logic [DW-1:0] m [N];
        logic [DW-1:0] got;
        bit            f  = 1'b0;
        int            fa = 0;
        logic [DW-1:0] fd = '0;
        int            fc = 0;
        foreach (m[i]) m[i] = '0;
        foreach (ref_ops[i]) begin
            if (ref_ops[i].wr) begin
                m[ref_ops[i].a] = ref_ops[i].d;
            end else begin
                got = (m[ref_ops[i].a] | stuck1[ref_ops[i].a]) & ~stuck0[ref_ops[i].a];
                if (got != ref_ops[i].d) begin
                    if (!f) begin
                        fa = ref_ops[i].a;
                        fd = got ^ ref_ops[i].d;
                    end
                    f = 1'b1;
                    if (fc < CNT_MAX) fc++;
                end
            end
        end
        return 64'({f, AW'(fa), fd, CW'(fc)});
    endfunction

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input logic e, m, w, r, input logic [AW-1:0] a,
                                         input logic [DW-1:0] di, b, input logic bz, dn);
        return 64'({e, m, w, r, a, di, b, bz, dn});
    endfunction

    function automatic logic [63:0] port_now();
        return pack(en, men, wen, ren, addr, din, bm, busy, done);
    endfunction

    function automatic logic [63:0] status_now();
        return 64'({fail, fail_addr, fail_data, fail_cnt});
    endfunction

    task automatic clear_faults();
        foreach (stuck1[i]) begin
            stuck1[i] = '0;
            stuck0[i] = '0;
        end
    endtask

    logic [AW-1:0] cap_e3_first, cap_e3_last;
    logic [63:0]   cap_p1;
    int            last_busy;

    // Starts a run and checks the port every cycle against the reference stream.
    // restart_at / abort_at: cycle to re-pulse start / assert reset (-1 = never).
    task automatic run_march(input string tag, input int restart_at, input int abort_at);
        op_t         o;
        logic [63:0] want;
        int          busy_cycles = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 0; cyc <= OPS + 1; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc < OPS) begin
                o    = ref_ops[cyc];
                want = pack(1'b1, 1'b1, o.wr, !o.wr, AW'(o.a), o.wr ? o.d : '0, '1, 1'b1, 1'b0);
            end else if (cyc == OPS) begin
                want = pack(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
            end else begin
                want = pack(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1);
            end
            check($sformatf("%s port cyc %0d", tag, cyc), port_now(), want);
            busy_cycles += int'(busy);
            if (cyc == 0) check($sformatf("%s status cleared", tag), status_now(), 64'h0);
            if (cyc == 5 * N)     cap_e3_first = addr;
            if (cyc == 7 * N - 1) cap_e3_last  = addr;
            if (cyc == 10 * N)    cap_p1       = 64'({wen, addr, din});
            if (cyc == restart_at) start = 1'b1;
            if (cyc == abort_at) begin
                rst = 1'b1;
                #1;
                check($sformatf("%s async reset port", tag), port_now(), 64'h0);
                check($sformatf("%s async reset status", tag), status_now(), 64'h0);
                @(negedge clk);
                rst = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check($sformatf("%s idle after reset", tag), port_now(), 64'h0);
                end
                return;
            end
        end
        last_busy = busy_cycles;
        check($sformatf("%s busy cycles", tag), 64'(busy_cycles), 64'(OPS + 1));
        check($sformatf("%s result", tag), status_now(), model_status());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, fa, fb, rs;
        rst   = 1'b0;
        start = 1'b0;
        foreach (mem[i]) mem[i] = '0;
        clear_faults();
        build_ref();
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset port", port_now(), 64'h0);
        check("reset status", status_now(), 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle port", port_now(), 64'h0);

        // Clean run.
        run_march("clean", -1, -1);
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
        check("clean busy literal", 64'(last_busy), 64'd321);
        check("pass1 first write", cap_p1, 64'({1'b1, 4'd0, 16'h5555}));
`else
        check("clean busy literal", 64'(last_busy), 64'd161);
`endif
        check("clean result literal", 64'({done, fail, fail_cnt}), 64'({1'b1, 1'b0, 4'd0}));
        check("E3 first addr", 64'(cap_e3_first), 64'd15);
        check("E3 last addr", 64'(cap_e3_last), 64'd0);

        // Stuck-at-1 on bit 3 of address 5.
        stuck1[5] = 16'h0008;
        run_march("stuck1", -1, -1);
`ifdef SRAM_BIST_ALT_BACKGROUND_EN
        check("stuck1 literal", status_now(), 64'({1'b1, 4'd5, 16'h0008, 4'd6}));
`else
        check("stuck1 literal", status_now(), 64'({1'b1, 4'd5, 16'h0008, 4'd3}));
`endif

        // Restart after DONE clears status; start at cycle 20 is ignored.
        clear_faults();
        run_march("restart", 20, -1);
        check("restart literal", 64'({fail, fail_cnt}), 64'h0);

        // Saturation: every cell stuck at 0.
        foreach (stuck0[i]) stuck0[i] = '1;
        run_march("sat", -1, -1);
        check("sat literal", status_now(), 64'({1'b1, 4'd0, 16'hFFFF, 4'd15}));

        // Reset mid-run with a failure already recorded, then a clean rerun.
        clear_faults();
        stuck1[0] = 16'h8001;
        run_march("abort", -1, 50);
        clear_faults();
        run_march("after abort", -1, -1);
        check("after abort busy literal", 64'(last_busy), 64'(10 * N * PASSES + 1));

        // Randomized faults, gaps and ignored restarts.
        for (int t = 0; t < 6; t++) begin
            clear_faults();
            nf = int'($urandom_range(0, 3));
            for (int k = 0; k < nf; k++) begin
                fa = int'($urandom_range(0, N - 1));
                fb = int'($urandom_range(0, DW - 1));
                if ($urandom_range(0, 1) == 1) stuck1[fa][fb] = 1'b1;
                else                           stuck0[fa][fb] = 1'b1;
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) rs = int'($urandom_range(1, OPS - 1));
            else                           rs = -1;
            run_march($sformatf("rand%0d", t), rs, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_1p_march_bist.md
# sram_1p_march_bist

March C- BIST controller for the single-port IHP SG13G2 SRAM macros with bit-mask and BIST port. It drives the macro's A_BIST_* port and checks A_DOUT, then reports pass/fail, the first failing address, its syndrome and a saturating failure count. It sits next to each macro instance in the test wrapper and is clocked by the same clock as A_BIST_CLK.

## Interface
- P_DATA_WIDTH, 16, macro word width
- P_ADDR_WIDTH, 12, macro address width; N = 2^P_ADDR_WIDTH words
- P_FAIL_CNT_WIDTH, 8, width of the saturating failure counter
- A_BIST_CLK  in  1  clock; also wired to the macro's A_BIST_CLK
- A_BIST_RST  in  1  reset, asynchronous, active-high
- BIST_START  in  1  start request, sampled on the rising edge
- A_DOUT  in  P_DATA_WIDTH  macro read data
- A_BIST_EN  out  1  macro port select; high only while BIST_BUSY
- A_BIST_MEN, A_BIST_WEN, A_BIST_REN  out  1 each  macro strobes
- A_BIST_ADDR  out  P_ADDR_WIDTH  macro address
- A_BIST_DIN  out  P_DATA_WIDTH  write data
- A_BIST_BM  out  P_DATA_WIDTH  bit mask; all ones whenever A_BIST_MEN is high
- BIST_BUSY  out  1  test running
- BIST_DONE  out  1  test finished; held until next start or reset
- BIST_FAIL  out  1  sticky; at least one miscompare
- BIST_FAIL_ADDR  out  P_ADDR_WIDTH  address of the first miscompare
- BIST_FAIL_DATA  out  P_DATA_WIDTH  first syndrome (A_DOUT XOR expected)
- BIST_FAIL_CNT  out  P_FAIL_CNT_WIDTH  miscompare count, saturating at all-ones

## Operation
- **States**
  - IDLE → RUN when BIST_START=1.
  - RUN → DRAIN after the last op of the last element.
  - DRAIN → DONE after one cycle.
  - DONE → RUN when BIST_START=1.
- **Start behaviour**
  - BIST_START in RUN or DRAIN is ignored.
  - On entering RUN: BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR, BIST_FAIL_DATA and BIST_FAIL_CNT clear to 0.
- **March elements**, with background B (per pass) and its inverse ~B:
  - E0 ⇑(wB)
  - E1 ⇑(rB, w~B)
  - E2 ⇑(r~B, wB)
  - E3 ⇓(rB, w~B)
  - E4 ⇓(r~B, wB)
  - E5 ⇑(rB)
  - ⇑ runs addresses 0..N-1; ⇓ runs N-1..0.
- **Ops**
  - All ops on one address complete before the address steps.
  - Each op takes one cycle. A_BIST_MEN=1 for every op; exactly one of A_BIST_WEN or A_BIST_REN is 1.
  - A_BIST_DIN is B or ~B on writes and 0 on reads.
- **Compare and capture**
  - Each read is compared one cycle later against the pipelined expected value and address.
  - On a miscompare: BIST_FAIL is set and BIST_FAIL_CNT increments (saturating).
  - BIST_FAIL_ADDR and BIST_FAIL_DATA are captured only when BIST_FAIL was 0.
- **Pass 0 background**: B = 0.
- **Outputs outside RUN**: all A_BIST_* outputs are 0 in IDLE, DRAIN and DONE.

## Timing
- All outputs are registered.
- Reset values: every output is 0 and the state is IDLE.
- Reset asserted mid-run forces A_BIST_EN and all strobes low immediately (asynchronously), with no partial result retained.
- **Start**: BIST_START high at edge 0 → the first op (w0, addr 0) is presented after edge 0 and sampled by the macro at edge 1.
- **Per pass**: the macro samples 10N ops, at edges 1..10N.
- **Read compare**: a read sampled at edge k is compared at edge k+1.
- **Completion**: the last compare happens at edge 10N+1 (DRAIN). BIST_BUSY falls and BIST_DONE rises after that edge, so BIST_BUSY is high for 10N+1 cycles.
- **Address wrap**: the counter wraps only at element boundaries; there is no idle cycle between elements.

## Configuration
- Macro: SRAM_BIST_ALT_BACKGROUND_EN.
- Defined: a second pass of E0–E5 follows pass 0 immediately, with B = {P_DATA_WIDTH/2{2'b01}} (16'h5555).
  - Ops are sampled at edges 1..20N; BIST_BUSY is high for 20N+1 cycles.
- Undefined: pass 0 only; the pass counter logic is absent.

## Structure
- Package sram_bist_pkg holds:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - element index type
  - constant march table: per element, direction, op count, and expected/written polarity
  - background constants
- One sub-module, sram_bist_cmp: the compare pipeline register, first-fail capture and saturating counter.
- The top level holds the FSM, element/op/address/pass counters and output registers.

## Test plan
All scenarios use P_ADDR_WIDTH=4, P_DATA_WIDTH=16 and a behavioral SRAM model.
- **Clean run**: one-cycle BIST_START → BIST_BUSY high 161 cycles, then BIST_DONE=1, BIST_FAIL=0, BIST_FAIL_CNT=0. A_BIST_ADDR sequence for E3 is 15..0.
- **Stuck-at-1**: bit 3 of addr 5 stuck at 1 → BIST_FAIL=1, BIST_FAIL_ADDR=5, BIST_FAIL_DATA=16'h0008, BIST_FAIL_CNT=3 (rB reads in E1, E3, E5).
- **Saturation**: P_FAIL_CNT_WIDTH=4 with all cells stuck at 0 → 32 r~B miscompares. BIST_FAIL_CNT=15, BIST_FAIL_ADDR=0, BIST_FAIL_DATA=16'hFFFF.
- **Reset mid-run**: A_BIST_RST pulsed at cycle 50 → all outputs 0 within the same cycle and state IDLE. A following BIST_START gives a clean 161-cycle pass.
- **Start while busy**: BIST_START re-pulsed at cycle 20 → ignored; BIST_BUSY is still 161 cycles. Pulse after BIST_DONE → status clears and the test reruns.
- **Alternate background**: with SRAM_BIST_ALT_BACKGROUND_EN defined → BIST_BUSY is 321 cycles. The first pass-1 write has A_BIST_DIN=16'h5555 at addr 0. The clean result passes.
